// File: rtl/cu_run_controller_if.sv
// Front-panel and CAR signal bundle for the run/step controller.
// master drives the raw panel/CAR inputs, slave is the controller.
interface cu_run_controller_if #(
  parameter int CNT_W = 16
);
  logic             i_btn_start;
  logic             i_btn_step;
  logic             i_sw_step_mode;
  logic             i_halt;
  logic             i_instr_boundary;
  logic             o_cpu_start;
  logic             o_step_execution;
  logic             o_next_instr_stimulus;
  logic             o_halted;
  logic [2:0]       o_state;
  logic [CNT_W-1:0] o_instr_count;

  modport master (
    output i_btn_start,
    output i_btn_step,
    output i_sw_step_mode,
    output i_halt,
    output i_instr_boundary,
    input  o_cpu_start,
    input  o_step_execution,
    input  o_next_instr_stimulus,
    input  o_halted,
    input  o_state,
    input  o_instr_count
  );

  modport slave (
    input  i_btn_start,
    input  i_btn_step,
    input  i_sw_step_mode,
    input  i_halt,
    input  i_instr_boundary,
    output o_cpu_start,
    output o_step_execution,
    output o_next_instr_stimulus,
    output o_halted,
    output o_state,
    output o_instr_count
  );
endinterface

// File: rtl/cu_run_controller.sv
// Run/step controller: debounced panel inputs sequence the CAR,
// detect halt at instruction boundaries and count retired instrs.
module cu_run_controller #(
  parameter int DB_W      = 16,
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input logic           i_clk,
  input logic           i_rst_n,
  cu_run_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_RUN  = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_HALTED    = 3'd4
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DB_CYCLES - 1);

  // bit 0 = start, bit 1 = step, bit 2 = mode switch
  logic [2:0]      raw;
  logic [2:0]      sy1;
  logic [2:0]      sy2;
  logic [2:0]      stab;
  logic [1:0]      stab_d;
  logic [DB_W-1:0] dbc [3];

  logic            start_press;
  logic            step_press;
  logic            mode_q;

  state_t           state;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             stim_q;
  logic             bnd_d;
  logic             bnd_rise;

  assign raw = {bus.i_sw_step_mode,
                bus.i_btn_step,
                bus.i_btn_start};

  // A level is accepted only after DB_CYCLES
  // consecutive cycles of disagreeing with stab.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sy1    <= '0;
      sy2    <= '0;
      stab   <= '0;
      stab_d <= '0;
      for (int k = 0; k < 3; k++) dbc[k] <= '0;
    end else begin
      sy1    <= raw;
      sy2    <= sy1;
      stab_d <= stab[1:0];
      for (int k = 0; k < 3; k++) begin
        if (sy2[k] == stab[k]) begin
          dbc[k] <= '0;
        end else if (dbc[k] == DB_LAST) begin
          dbc[k]  <= '0;
          stab[k] <= sy2[k];
        end else begin
          dbc[k] <= dbc[k] + DB_W'(1);
        end
      end
    end
  end

  assign start_press = stab[0] & ~stab_d[0];
  assign step_press  = stab[1] & ~stab_d[1];
  assign mode_q      = stab[2];

  assign bnd_rise = bus.i_instr_boundary & ~bnd_d;
  assign cnt_inc  = (&cnt_q) ? cnt_q
                             : cnt_q + CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      cnt_q  <= '0;
      stim_q <= 1'b0;
      bnd_d  <= 1'b0;
    end else begin
      bnd_d  <= bus.i_instr_boundary;
      stim_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_press) begin
            state <= mode_q ? S_STEP_RUN : S_RUN;
            cnt_q <= '0;
          end
        end
        S_RUN: begin
          if (bnd_rise) begin
            cnt_q <= cnt_inc;
            if (bus.i_halt)
              state <= S_HALTED;
            else if (mode_q)
              state <= S_STEP_WAIT;
          end
        end
        S_STEP_RUN: begin
          if (bnd_rise) begin
            cnt_q <= cnt_inc;
            state <= bus.i_halt ? S_HALTED
                                : S_STEP_WAIT;
          end else if (!mode_q) begin
            state <= S_RUN;
          end
        end
        S_STEP_WAIT: begin
          if (!mode_q) begin
            state <= S_RUN;
          end else if (step_press &&
                       bus.i_instr_boundary) begin
            state  <= S_STEP_RUN;
            stim_q <= 1'b1;
          end
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_cpu_start      = (state != S_IDLE);
  assign bus.o_step_execution =
    mode_q & ((state == S_RUN) ||
              (state == S_STEP_RUN) ||
              (state == S_STEP_WAIT));
  assign bus.o_next_instr_stimulus = stim_q;
  assign bus.o_halted      = (state == S_HALTED);
  assign bus.o_state       = state;
  assign bus.o_instr_count = cnt_q;

endmodule

// File: tb/tb_cu_run_controller.sv
// Scoreboard bench for cu_run_controller: operation-level model
// predicts every change of the output vector, monitor checks them.
module tb_cu_run_controller;

  localparam int CW = 3;
  localparam int DB = 4;

  localparam logic [2:0] M_IDLE  = 3'd0;
  localparam logic [2:0] M_RUN   = 3'd1;
  localparam logic [2:0] M_SRUN  = 3'd2;
  localparam logic [2:0] M_SWAIT = 3'd3;
  localparam logic [2:0] M_HALT  = 3'd4;

  typedef struct packed {
    logic [2:0]    st;
    logic          cs;
    logic          se;
    logic          stim;
    logic          h;
    logic [CW-1:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  cu_run_controller_if #(.CNT_W(CW)) bus ();

  cu_run_controller #(
    .DB_W      (8),
    .DB_CYCLES (DB),
    .CNT_W     (CW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  obs_t expq[$];
  obs_t last_pushed = '0;

  // model state
  logic [2:0]    m_st   = M_IDLE;
  logic          m_mode = 1'b0;
  logic          m_bnd  = 1'b0;
  logic [CW-1:0] m_cnt  = '0;

  function automatic obs_t sample();
    obs_t v;
    v.st   = bus.o_state;
    v.cs   = bus.o_cpu_start;
    v.se   = bus.o_step_execution;
    v.stim = bus.o_next_instr_stimulus;
    v.h    = bus.o_halted;
    v.cnt  = bus.o_instr_count;
    return v;
  endfunction

  function automatic obs_t mk(logic stim);
    obs_t v;
    v.st   = m_st;
    v.cs   = (m_st != M_IDLE);
    v.se   = m_mode && (m_st == M_RUN ||
                        m_st == M_SRUN ||
                        m_st == M_SWAIT);
    v.stim = stim;
    v.h    = (m_st == M_HALT);
    v.cnt  = m_cnt;
    return v;
  endfunction

  task automatic push(input logic stim);
    obs_t v;
    v = mk(stim);
    if (v != last_pushed) begin
      expq.push_back(v);
      last_pushed = v;
    end
  endtask

  task automatic check(input string nm,
                       input obs_t got,
                       input obs_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t",
                  nm, got, exp, $time);
  endtask

  // monitor: every change of the DUT outputs is an event
  initial begin
    obs_t cur;
    obs_t prev;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = sample();
      if (cur !== prev) begin
        if (expq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected got=%h exp=none t=%0t",
                   cur, $time);
        end else begin
          check("event", cur, expq.pop_front());
        end
        prev = cur;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_start();
    if (m_st == M_IDLE) begin
      m_st  = m_mode ? M_SRUN : M_RUN;
      m_cnt = '0;
      push(1'b0);
    end
  endtask

  task automatic m_reset();
    m_st  = M_IDLE;
    m_cnt = '0;
    push(1'b0);
  endtask

  task automatic op_start();
    m_start();
    bus.i_btn_start = 1'b1;
    tick(DB + 8);
    bus.i_btn_start = 1'b0;
    tick(DB + 8);
  endtask

  task automatic op_step();
    if (m_st == M_SWAIT && m_bnd) begin
      m_st = M_SRUN;
      push(1'b1);
      push(1'b0);
    end
    bus.i_btn_step = 1'b1;
    tick(DB + 8);
    bus.i_btn_step = 1'b0;
    tick(DB + 8);
  endtask

  task automatic op_mode(input logic v);
    if (v != m_mode) begin
      m_mode = v;
      push(1'b0);
      if (!v && (m_st == M_SRUN || m_st == M_SWAIT)) begin
        m_st = M_RUN;
        push(1'b0);
      end
    end
    bus.i_sw_step_mode = v;
    tick(DB + 10);
  endtask

  task automatic op_bnd_up(input logic h);
    if (!m_bnd) begin
      m_bnd = 1'b1;
      if (m_st == M_RUN || m_st == M_SRUN) begin
        if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        if (h)
          m_st = M_HALT;
        else if (m_st == M_SRUN || m_mode)
          m_st = M_SWAIT;
      end
      push(1'b0);
    end
    bus.i_instr_boundary = 1'b1;
    bus.i_halt = h;
    tick(3);
  endtask

  task automatic op_bnd_down();
    m_bnd = 1'b0;
    bus.i_instr_boundary = 1'b0;
    bus.i_halt = 1'b0;
    tick(3);
  endtask

  task automatic op_reset();
    m_reset();
    rst_n = 1'b0;
    #1;
    check("reset_async", sample(), '0);
    tick(2);
    rst_n = 1'b1;
    tick(DB + 10);
  endtask

  initial begin
    logic found;
    int   r;
    bus.i_btn_start      = 1'b0;
    bus.i_btn_step       = 1'b0;
    bus.i_sw_step_mode   = 1'b0;
    bus.i_halt           = 1'b0;
    bus.i_instr_boundary = 1'b0;
    #1 rst_n = 1'b0;
    tick(3);
    check("reset_state", sample(), '0);
    rst_n = 1'b1;
    tick(4);

    // bouncing start: one accepted press only
    m_start();
    bus.i_btn_start = 1'b1; tick(1);
    bus.i_btn_start = 1'b0; tick(1);
    bus.i_btn_start = 1'b1; tick(6);
    bus.i_btn_start = 1'b0; tick(DB + 8);

    // auto run: five instructions, last one halts
    for (int i = 0; i < 5; i++) begin
      op_bnd_up(i == 4);
      op_bnd_down();
    end
    op_start();
    op_step();
    op_mode(1'b1);
    op_bnd_up(1'b0);
    op_bnd_down();
    op_mode(1'b0);

    // step mode
    op_reset();
    op_mode(1'b1);
    op_start();
    op_bnd_up(1'b0);
    op_step();
    op_bnd_down();
    op_bnd_up(1'b0);
    op_mode(1'b0);
    op_mode(1'b1);
    op_bnd_down();
    op_bnd_up(1'b0);

    // reset while the stimulus pulse is high
    if (m_st == M_SWAIT && m_bnd) begin
      m_st = M_SRUN;
      push(1'b1);
    end
    bus.i_btn_step = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.o_next_instr_stimulus) found = 1'b1;
    end
    n_checks++;
    if (found) n_pass++;
    else $display("FAIL stim_wait got=0 exp=1");
    #1 rst_n = 1'b0;
    m_reset();
    #1 check("reset_mid_pulse", sample(), '0);
    bus.i_btn_step = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(DB + 10);

    // counter saturation
    op_bnd_down();
    op_mode(1'b0);
    op_start();
    for (int i = 0; i < 9; i++) begin
      op_bnd_up(1'b0);
      op_bnd_down();
    end

    // randomized operation mix
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      op_start();
      else if (r < 30) op_step();
      else if (r < 42) op_mode(~m_mode);
      else if (r < 68)
        op_bnd_up($urandom_range(0, 7) == 0);
      else if (r < 93) op_bnd_down();
      else             op_reset();
    end

    tick(20);
    n_checks++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d exp=0",
                  expq.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
